// File: rtl/relobi_cut.sv
// Reliable OBI cut: a TMR-hardened spill register on the A and R channels.
// Handshakes are voted on entry; each slot-full flag is kept in three copies.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    bit          UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32,
    DataWidth: 32,
    UseRReady: 1'b1
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
    logic [11:0] other_ecc;
  } relobi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
    logic        r_optional;
    logic [7:0]  other_ecc;
  } relobi_r_chan_t;

  typedef struct packed {
    logic [2:0]     req;
    logic [2:0]     rready;
    relobi_a_chan_t a;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0]     gnt;
    logic [2:0]     rvalid;
    relobi_r_chan_t r;
  } relobi_rsp_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic split3(input logic [2:0] v);
    return (|v) & ~(&v);
  endfunction

endpackage

module relobi_cut_chan #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o,
  output logic  split_o
);
  import obi_pkg::*;

  logic [2:0] a_full_q, a_full_d;
  logic [2:0] b_full_q, b_full_d;
  data_t      a_data_q, a_data_d;
  data_t      b_data_q, b_data_d;
  logic       a_full, b_full;
  logic       a_fill, a_drain;
  logic       b_fill, b_drain;

  assign a_full = maj3(a_full_q);
  assign b_full = maj3(b_full_q);

  // Next state comes from the voted flag, so a flipped copy heals in one cycle
  always_comb begin
    a_fill   = valid_i & ~b_full;
    a_drain  = a_full & ~b_full;
    b_fill   = a_drain & ~ready_i;
    b_drain  = b_full & ready_i;
    a_full_d = {3{a_fill | (a_full & ~a_drain)}};
    b_full_d = {3{b_fill | (b_full & ~b_drain)}};
    a_data_d = a_fill ? data_i : a_data_q;
    b_data_d = b_fill ? a_data_q : b_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_full_q <= '0;
      b_full_q <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end

  assign ready_o = ~b_full;
  assign valid_o = a_full | b_full;
  assign data_o  = b_full ? b_data_q : a_data_q;
  assign split_o = split3(a_full_q) | split3(b_full_q);

endmodule

module relobi_cut #(
  parameter obi_pkg::obi_cfg_t Cfg = obi_pkg::ObiDefaultConfig,
  parameter type relobi_req_t    = obi_pkg::relobi_req_t,
  parameter type relobi_rsp_t    = obi_pkg::relobi_rsp_t,
  parameter type relobi_a_chan_t = obi_pkg::relobi_a_chan_t,
  parameter type relobi_r_chan_t = obi_pkg::relobi_r_chan_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  relobi_req_t sbr_port_req_i,
  output relobi_rsp_t sbr_port_rsp_o,
  output relobi_req_t mgr_port_req_o,
  input  relobi_rsp_t mgr_port_rsp_i,
  output logic [1:0]  fault_o
);
  import obi_pkg::*;

  logic req_v, rready_v, gnt_v, rvalid_v;
  logic a_ready_up, a_valid_dn, a_split;
  logic r_ready_up, r_valid_dn, r_ready_dn, r_split;
  logic hs_split;
  relobi_a_chan_t a_payload;
  relobi_r_chan_t r_payload;

  assign req_v    = maj3(sbr_port_req_i.req);
  assign rready_v = maj3(sbr_port_req_i.rready);
  assign gnt_v    = maj3(mgr_port_rsp_i.gnt);
  assign rvalid_v = maj3(mgr_port_rsp_i.rvalid);

  // Without rready the upstream can never stall a response
  assign r_ready_dn = Cfg.UseRReady ? rready_v : 1'b1;

  assign hs_split = split3(sbr_port_req_i.req)
                  | split3(mgr_port_rsp_i.gnt)
                  | split3(mgr_port_rsp_i.rvalid)
                  | (Cfg.UseRReady & split3(sbr_port_req_i.rready));

  relobi_cut_chan #(
    .data_t (relobi_a_chan_t)
  ) u_a_cut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (req_v),
    .ready_o (a_ready_up),
    .data_i  (sbr_port_req_i.a),
    .valid_o (a_valid_dn),
    .ready_i (gnt_v),
    .data_o  (a_payload),
    .split_o (a_split)
  );

  relobi_cut_chan #(
    .data_t (relobi_r_chan_t)
  ) u_r_cut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rvalid_v),
    .ready_o (r_ready_up),
    .data_i  (mgr_port_rsp_i.r),
    .valid_o (r_valid_dn),
    .ready_i (r_ready_dn),
    .data_o  (r_payload),
    .split_o (r_split)
  );

  always_comb begin
    mgr_port_req_o        = '0;
    mgr_port_req_o.req    = {3{a_valid_dn}};
    mgr_port_req_o.rready = Cfg.UseRReady ? {3{r_ready_up}} : 3'b111;
    mgr_port_req_o.a      = a_payload;
    sbr_port_rsp_o        = '0;
    sbr_port_rsp_o.gnt    = {3{a_ready_up}};
    sbr_port_rsp_o.rvalid = {3{r_valid_dn}};
    sbr_port_rsp_o.r      = r_payload;
  end

  assign fault_o = {a_split | r_split, hs_split};

endmodule

// File: tb/tb_relobi_cut.sv
// Randomised and directed bench for relobi_cut.
// A two-deep FIFO model with a one-cycle stall memory predicts both channels.
module tb_relobi_cut;
  import obi_pkg::*;

  localparam int AB = $bits(relobi_a_chan_t);
  localparam int RB = $bits(relobi_r_chan_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  relobi_req_t sbr_req, mgr_req;
  relobi_rsp_t sbr_rsp, mgr_rsp;
  logic [1:0] fault;

  logic sreq, srready, mgnt, mrvalid;
  logic [2:0] m_req, m_rr, m_gnt, m_rv;
  relobi_a_chan_t a_pay;
  relobi_r_chan_t r_pay;
  logic exp_f1 = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  always_comb begin
    sbr_req        = '0;
    sbr_req.req    = {3{sreq}} ^ m_req;
    sbr_req.rready = {3{srready}} ^ m_rr;
    sbr_req.a      = a_pay;
    mgr_rsp        = '0;
    mgr_rsp.gnt    = {3{mgnt}} ^ m_gnt;
    mgr_rsp.rvalid = {3{mrvalid}} ^ m_rv;
    mgr_rsp.r      = r_pay;
  end

  relobi_cut dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sbr_port_req_i (sbr_req),
    .sbr_port_rsp_o (sbr_rsp),
    .mgr_port_req_o (mgr_req),
    .mgr_port_rsp_i (mgr_rsp),
    .fault_o        (fault)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Model: FIFO order, upstream stalls iff downstream stalled last cycle
  relobi_a_chan_t qa[$];
  relobi_r_chan_t qr[$];
  bit a_st, r_st, vd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qr.delete();
      a_st = 1'b0;
      r_st = 1'b0;
    end else begin
      vd = qa.size() != 0;
      if (vd && mgnt) void'(qa.pop_front());
      if (sreq && !a_st) qa.push_back(a_pay);
      a_st = vd && !mgnt;
      vd = qr.size() != 0;
      if (vd && srready) void'(qr.pop_front());
      if (mrvalid && !r_st) qr.push_back(r_pay);
      r_st = vd && !srready;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", 128'(mgr_req.req), 128'(3'b000));
      chk("rst_gnt", 128'(sbr_rsp.gnt), 128'(3'b111));
      chk("rst_rvalid", 128'(sbr_rsp.rvalid), 128'(3'b000));
      chk("rst_rready", 128'(mgr_req.rready), 128'(3'b111));
    end else begin
      chk("gnt", 128'(sbr_rsp.gnt), 128'(a_st ? 3'b000 : 3'b111));
      chk("req", 128'(mgr_req.req), 128'(qa.size() != 0 ? 3'b111 : 3'b000));
      if (qa.size() != 0) chk("a_pay", 128'(mgr_req.a), 128'(qa[0]));
      chk("rready", 128'(mgr_req.rready), 128'(r_st ? 3'b000 : 3'b111));
      chk("rvalid", 128'(sbr_rsp.rvalid),
          128'(qr.size() != 0 ? 3'b111 : 3'b000));
      if (qr.size() != 0) chk("r_pay", 128'(sbr_rsp.r), 128'(qr[0]));
    end
    chk("fault0", 128'(fault[0]),
        128'((m_req != 0) || (m_rr != 0) || (m_gnt != 0) || (m_rv != 0)));
    chk("fault1", 128'(fault[1]), 128'(exp_f1));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_a();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    a_pay = relobi_a_chan_t'(t[AB-1:0]);
  endtask

  task automatic rand_r();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    r_pay = relobi_r_chan_t'(t[RB-1:0]);
  endtask

  task automatic idle();
    sreq = 0; srready = 1; mgnt = 1; mrvalid = 0;
    m_req = 0; m_rr = 0; m_gnt = 0; m_rv = 0;
  endtask

  function automatic logic [2:0] flip();
    if ($urandom_range(0, 7) != 0) return 3'b000;
    return 3'b001 << $urandom_range(0, 2);
  endfunction

  relobi_a_chan_t w;
  int cnt, nxt, up, dn, sacc;
  logic acc;

  initial begin
    idle();
    rand_a();
    rand_r();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fault", 128'(fault), 128'(2'b00));
    step();
    rst = 0;

    // single write with ECC bits
    step();
    rand_a();
    a_pay.addr = 32'h100;
    w = a_pay;
    sreq = 1;
    #1 chk("t1_gnt", 128'(sbr_rsp.gnt), 128'(3'b111));
    step();
    sreq = 0;
    #1 chk("t1_req", 128'(mgr_req.req), 128'(3'b111));
    chk("t1_a", 128'(mgr_req.a), 128'(w));
    step();
    #1 chk("t1_done", 128'(mgr_req.req), 128'(3'b000));

    // 8 back-to-back with downstream always granting
    cnt = 0; nxt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      sreq = (i < 8);
      rand_a();
      a_pay.addr = 32'h200 + i;
      #1;
      if (mgr_req.req == 3'b111) begin
        chk("t2_order", 128'(mgr_req.a.addr), 128'(32'h200 + nxt));
        nxt++;
        if (i < 9) cnt++;
      end
    end
    chk("t2_count", 128'(cnt), 128'(8));

    // downstream stall for 4 cycles mid-stream
    up = 0; dn = 0; sacc = 0;
    for (int c = 0; c < 18; c++) begin
      step();
      sreq = (c < 12);
      rand_a();
      a_pay.addr = 32'h300 + up;
      mgnt = !(c >= 4 && c < 8);
      #1;
      acc = sreq && (sbr_rsp.gnt == 3'b111);
      if (acc) up++;
      if (acc && c >= 4 && c < 8) sacc++;
      if (c == 5) chk("t3_gnt_drop", 128'(sbr_rsp.gnt), 128'(3'b000));
      if (mgr_req.req == 3'b111 && mgnt) begin
        chk("t3_order", 128'(mgr_req.a.addr), 128'(32'h300 + dn));
        dn++;
      end
    end
    chk("t3_stall_acc", 128'(sacc), 128'(1));
    chk("t3_no_loss", 128'(dn), 128'(up));

    // one corrupted req copy
    step();
    rand_a();
    a_pay.addr = 32'h400;
    sreq = 1;
    m_req = 3'b010;
    #1 chk("t4_fault0", 128'(fault[0]), 128'(1'b1));
    step();
    sreq = 0;
    m_req = 0;
    #1 chk("t4_fault0_clr", 128'(fault[0]), 128'(1'b0));
    chk("t4_req", 128'(mgr_req.req), 128'(3'b111));
    chk("t4_addr", 128'(mgr_req.a.addr), 128'(32'h400));

    // flip one copy of the A full flag
    for (int c = 0; c < 6; c++) begin
      step();
      exp_f1 = 0;
      sreq = (c < 5);
      rand_a();
      if (c == 3) begin
        force dut.u_a_cut.a_full_q = 3'b101;
        exp_f1 = 1;
        #1 chk("t5_fault1", 128'(fault[1]), 128'(1'b1));
        #4 release dut.u_a_cut.a_full_q;
      end
      if (c == 4) begin
        #1 chk("t5_fault1_clr", 128'(fault[1]), 128'(1'b0));
        chk("t5_copies", 128'(dut.u_a_cut.a_full_q), 128'(3'b111));
      end
    end

    // reset with B full
    step();
    sreq = 1; mgnt = 0; rand_a();
    step();
    rand_a();
    step();
    #1 chk("t6_bfull", 128'(sbr_rsp.gnt), 128'(3'b000));
    #1 rst = 1;
    #1 chk("t6_req", 128'(mgr_req.req), 128'(3'b000));
    chk("t6_gnt", 128'(sbr_rsp.gnt), 128'(3'b111));
    chk("t6_fault", 128'(fault), 128'(2'b00));
    step();
    sreq = 0; mgnt = 1;
    step();
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      #1 chk("t6_noemit", 128'(mgr_req.req), 128'(3'b000));
    end

    // random traffic on both channels, one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      step();
      sreq    = $urandom_range(0, 3) != 0;
      mgnt    = $urandom_range(0, 3) != 0;
      mrvalid = $urandom_range(0, 2) != 0;
      srready = $urandom_range(0, 3) != 0;
      m_req = flip(); m_rr = flip(); m_gnt = flip(); m_rv = flip();
      rand_a();
      rand_r();
      if (i == 1500) begin
        #1 rst = 1;
      end
      if (i == 1503) rst = 0;
    end

    idle();
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
